// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution coefficient sequencer.
package conv_pkg;

  localparam int NCOEFF  = 25;
  localparam int COEFF_W = 16;
  localparam int IDX_W   = $clog2(NCOEFF);

  // 1.0 in signed s7.8
  localparam logic [COEFF_W-1:0] COEFF_ONE = 16'h0100;

  // Index bounds pre-sized to the index width for clean comparisons
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NCOEFF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCOEFF - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_t;

  // Identity kernel: unity weight on the centre tap, zero elsewhere
  function automatic logic [COEFF_W-1:0] identity_coeff(input int idx);
    return (idx == NCOEFF / 2) ? COEFF_ONE : '0;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// Two-bank coefficient register file: one synchronous write port, one
// combinational read port, both banks reset to the identity kernel.
module coeff_bank
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               wr_bank,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic               rd_bank,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [COEFF_W-1:0] rd_data
);

  logic [COEFF_W-1:0] mem [2][NCOEFF];

  // Write port; out-of-range addresses are dropped here as a second guard
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NCOEFF; i++) begin
          mem[b][i] <= identity_coeff(i);
        end
      end
    end else if (we && (wr_addr < IDX_END)) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Zero-latency read so the streamed tap lines up with the index counter
  always_comb begin
    rd_data = '0;
    if (rd_addr < IDX_END) begin
      rd_data = mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/conv_coeff_sequencer.sv
// Streams the active 5x5 kernel to the convolution datapath during the
// vs_i window, while the host edits the shadow bank and commits swaps
// that only take effect outside the window.
module conv_coeff_sequencer
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_i,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [COEFF_W-1:0] cfg_data,
  input  logic               cfg_commit,
  input  logic               cfg_err_clr,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic [COEFF_W-1:0] coeff_o,
  output logic [IDX_W-1:0]   coeff_idx_o,
  output logic               load_done_o,
  output logic               active_bank_o,
  output logic [15:0]        frame_cnt_o
);

  cfg_state_t         state_reg;
  logic               cfg_ready_reg;
  logic               cfg_err_reg;
  logic               active_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               load_done_reg;
  logic [15:0]        frame_cnt_reg;
  logic [COEFF_W-1:0] rd_data;

  logic addr_ok;
  logic wr_ok;
  logic wr_bad;
  logic commit_ok;

  assign addr_ok   = (cfg_addr < IDX_END);
  assign wr_ok     = cfg_we & cfg_ready_reg & addr_ok;
  assign wr_bad    = cfg_we & ~(cfg_ready_reg & addr_ok);
  assign commit_ok = cfg_commit & cfg_ready_reg;

  // Host writes always target the bank not being streamed
  coeff_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_ok),
    .wr_bank (~active_reg),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_bank (active_reg),
    .rd_addr (idx_reg),
    .rd_data (rd_data)
  );

  // Tap index: cleared outside the window, counts up inside it and parks
  // one past the last tap; the step onto the park value marks a full load
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      load_done_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      load_done_reg <= 1'b0;
      if (!vs_i) begin
        idx_reg <= '0;
      end else if (idx_reg != IDX_END) begin
        idx_reg <= idx_reg + 1'b1;
        if (idx_reg == IDX_LAST) begin
          load_done_reg <= 1'b1;
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
      end
    end
  end

  // Commit/swap FSM: a commit is registered first, then the swap waits for
  // the window to close so a frame never mixes two kernels
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cfg_ready_reg <= 1'b1;
      active_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (commit_ok) begin
            state_reg     <= ST_PEND;
            cfg_ready_reg <= 1'b0;
          end
        end
        ST_PEND: begin
          if (!vs_i) begin
            state_reg     <= ST_IDLE;
            cfg_ready_reg <= 1'b1;
            active_reg    <= ~active_reg;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          cfg_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error for rejected writes; an explicit clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_reg <= 1'b0;
    end else if (cfg_err_clr) begin
      cfg_err_reg <= 1'b0;
    end else if (wr_bad) begin
      cfg_err_reg <= 1'b1;
    end
  end

  // Past the last tap the datapath sees zero
  always_comb begin
    coeff_o = '0;
    if (idx_reg < IDX_END) begin
      coeff_o = rd_data;
    end
  end

  assign coeff_idx_o   = idx_reg;
  assign load_done_o   = load_done_reg;
  assign frame_cnt_o   = frame_cnt_reg;
  assign active_bank_o = active_reg;
  assign cfg_ready     = cfg_ready_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_conv_coeff_sequencer.sv
// Directed bench for conv_coeff_sequencer: identity stream after reset,
// bank rewrite and commit, commit inside the window, rejected writes,
// short window, and reset mid-stream with a swap pending.
module tb_conv_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_i;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_err_clr;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] coeff_o;
  logic [4:0]  coeff_idx_o;
  logic        load_done_o;
  logic        active_bank_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;

  // Expected-state tracking for the bench
  logic [15:0] model_bank [2][25];
  int          model_active;
  int          model_pending;
  int          model_frame;

  conv_coeff_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .vs_i          (vs_i),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_commit    (cfg_commit),
    .cfg_err_clr   (cfg_err_clr),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .coeff_o       (coeff_o),
    .coeff_idx_o   (coeff_idx_o),
    .load_done_o   (load_done_o),
    .active_bank_o (active_bank_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_identity();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 25; i++)
        model_bank[b][i] = (i == 12) ? 16'h0100 : 16'h0000;
    model_active  = 0;
    model_pending = 0;
    model_frame   = 0;
  endtask

  // One vs_i window of len cycles; optional commit at window cycle commit_at.
  // Ends after the first vs_i-low edge (where any pending swap lands).
  task automatic run_window(input string name, input int len, input int commit_at);
    logic [15:0] exp_coeff;
    vs_i = 1'b1;
    for (int n = 0; n < len; n++) begin
      exp_coeff = (n < 25) ? model_bank[model_active][n] : 16'h0000;
      check($sformatf("%s idx n=%0d", name, n), 32'(coeff_idx_o), 32'((n < 25) ? n : 25));
      check($sformatf("%s coeff n=%0d", name, n), 32'(coeff_o), 32'(exp_coeff));
      check($sformatf("%s done n=%0d", name, n), 32'(load_done_o), 32'(n == 25));
      check($sformatf("%s bank n=%0d", name, n), 32'(active_bank_o), 32'(model_active));
      check($sformatf("%s ready n=%0d", name, n), 32'(cfg_ready), 32'(model_pending == 0));
      if (n == commit_at) cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
      if (n == commit_at) model_pending = 1;
    end
    vs_i = 1'b0;
    if (len >= 25) model_frame++;
    check($sformatf("%s bank before fall", name), 32'(active_bank_o), 32'(model_active));
    step();
    if (model_pending != 0) begin
      model_active  = 1 - model_active;
      model_pending = 0;
    end
    check($sformatf("%s idx after", name), 32'(coeff_idx_o), 32'd0);
    check($sformatf("%s bank after", name), 32'(active_bank_o), 32'(model_active));
    check($sformatf("%s ready after", name), 32'(cfg_ready), 32'd1);
    check($sformatf("%s frames", name), 32'(frame_cnt_o), 32'(model_frame));
    check($sformatf("%s done after", name), 32'(load_done_o), 32'd0);
    $display("window %s len=%0d bank=%0d frames=%0d", name, len, model_active, model_frame);
  endtask

  initial begin
    rst = 1'b1; vs_i = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; cfg_err_clr = 1'b0;
    model_identity();
    repeat (3) step();

    // Reset state
    check("rst idx", 32'(coeff_idx_o), 32'd0);
    check("rst bank", 32'(active_bank_o), 32'd0);
    check("rst ready", 32'(cfg_ready), 32'd1);
    check("rst err", 32'(cfg_err), 32'd0);
    check("rst frames", 32'(frame_cnt_o), 32'd0);
    check("rst done", 32'(load_done_o), 32'd0);
    check("rst coeff", 32'(coeff_o), 32'd0);
    rst = 1'b0;

    // 1: identity kernel streamed
    run_window("t1", 30, -1);

    // 2: rewrite shadow bank 1, commit on the last write
    for (int k = 0; k < 25; k++) begin
      cfg_we = 1'b1; cfg_addr = 5'(k); cfg_data = 16'h0010 + 16'(k);
      if (k == 24) cfg_commit = 1'b1;
      step();
      model_bank[1][k] = 16'h0010 + 16'(k);
    end
    cfg_we = 1'b0; cfg_commit = 1'b0;
    check("t2 ready low", 32'(cfg_ready), 32'd0);
    check("t2 bank before swap", 32'(active_bank_o), 32'd0);
    check("t2 err", 32'(cfg_err), 32'd0);
    step();
    model_active = 1;
    check("t2 ready back", 32'(cfg_ready), 32'd1);
    check("t2 bank swapped", 32'(active_bank_o), 32'd1);
    $display("t2 wrote bank 1 and swapped");
    run_window("t2", 30, -1);

    // 3: commit at idx 10; window keeps bank 1, swap to bank 0 after fall
    run_window("t3", 30, 10);

    // 4: rejected writes
    cfg_we = 1'b1; cfg_addr = 5'd25; cfg_data = 16'hBEEF;
    step();
    cfg_we = 1'b0;
    check("t4 err bad addr", 32'(cfg_err), 32'd1);
    cfg_err_clr = 1'b1;
    step();
    cfg_err_clr = 1'b0;
    check("t4 err cleared", 32'(cfg_err), 32'd0);
    vs_i = 1'b1; cfg_commit = 1'b1;
    step();
    model_pending = 1;
    check("t4 pending ready", 32'(cfg_ready), 32'd0);
    step();
    cfg_commit = 1'b0;
    check("t4 commit while pending no err", 32'(cfg_err), 32'd0);
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 16'h7777;
    step();
    check("t4 err write pending", 32'(cfg_err), 32'd1);
    cfg_err_clr = 1'b1;
    step();
    cfg_we = 1'b0; cfg_err_clr = 1'b0;
    check("t4 clr wins", 32'(cfg_err), 32'd0);
    check("t4 bank held in window", 32'(active_bank_o), 32'd0);
    vs_i = 1'b0;
    step();
    model_active = 1; model_pending = 0;
    check("t4 swap bank", 32'(active_bank_o), 32'd1);
    check("t4 ready", 32'(cfg_ready), 32'd1);
    check("t4 idx", 32'(coeff_idx_o), 32'd0);
    $display("t4 rejected writes checked");
    run_window("t4", 30, -1);

    // 5: short window
    run_window("t5", 12, -1);

    // 6: reset at idx 7 with a swap pending
    vs_i = 1'b1;
    for (int n = 0; n < 7; n++) begin
      if (n == 2) cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
    end
    check("t6 idx before rst", 32'(coeff_idx_o), 32'd7);
    check("t6 pending before rst", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; vs_i = 1'b0;
    model_identity();
    check("t6 idx", 32'(coeff_idx_o), 32'd0);
    check("t6 bank", 32'(active_bank_o), 32'd0);
    check("t6 ready", 32'(cfg_ready), 32'd1);
    check("t6 frames", 32'(frame_cnt_o), 32'd0);
    check("t6 done", 32'(load_done_o), 32'd0);
    $display("t6 reset mid-stream");
    run_window("t6a", 30, 0);
    run_window("t6b", 30, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
